// File: rtl/risc_fsm_controller_if.sv
// risc_fsm_controller_if
// Bundles the start/decode inputs and the datapath control outputs of the
// RISC control FSM. Clock and reset stay outside as plain module ports.
//
// Signals:
//   s       start pulse, sampled only while the controller waits
//   opcode  instruction[15:13]
//   op      instruction[12:11]
//   w       ready (controller is in WAIT)
//   nsel    one-hot register select: 001 Rm, 010 Rd, 100 Rn, 000 none
//   vsel    write-back source: 00 datapath C, 10 sximm8
//   loada/loadb/loadc/loads  datapath register enables
//   asel    ALU A operand forced to zero
//   bsel    ALU B operand sximm5 select (unused by this controller, held 0)
//   write   register-file write enable
//   err     sticky illegal-instruction flag
//
// Modports: master = instruction source / datapath side, slave = controller.
interface risc_fsm_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;
  logic       err;

  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );
endinterface

// File: rtl/risc_fsm_controller.sv
// risc_fsm_controller
// Moore control FSM for a small RISC datapath. In WAIT it latches the
// instruction's opcode/op on a start pulse, then sequences the datapath
// through operand fetch, ALU and write-back. Unknown instructions set a
// sticky err flag and return straight to WAIT.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (forces WAIT, clears all controls)
//   bus    risc_fsm_controller_if.slave: s/opcode/op in, control outputs out
//
// Every output is a register loaded with the value belonging to the state
// being entered, so outputs change only on clk or reset and never glitch.
module risc_fsm_controller (
  input  logic                        clk,
  input  logic                        reset,
  risc_fsm_controller_if.slave        bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [2:0] r_opcode;
  logic [1:0] r_op;

  logic       r_w;
  logic [2:0] r_nsel;
  logic [1:0] r_vsel;
  logic       r_loada;
  logic       r_loadb;
  logic       r_loadc;
  logic       r_loads;
  logic       r_asel;
  logic       r_bsel;
  logic       r_write;
  logic       r_err;

  // Instruction classes, decoded only from the latched copy so that input
  // activity after the start edge cannot steer the sequence.
  logic w_mov_imm;
  logic w_mov_reg;
  logic w_mvn;
  logic w_add_and;
  logic w_cmp;
  logic w_latched_legal;
  logic w_start;

  function automatic logic f_is_legal(input logic [2:0] opc, input logic [1:0] o);
    logic legal;
    case ({opc, o})
      5'b110_10, 5'b110_00, 5'b101_11,
      5'b101_00, 5'b101_01, 5'b101_10: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign w_mov_imm       = (r_opcode == 3'b110) && (r_op == 2'b10);
  assign w_mov_reg       = (r_opcode == 3'b110) && (r_op == 2'b00);
  assign w_mvn           = (r_opcode == 3'b101) && (r_op == 2'b11);
  assign w_add_and       = (r_opcode == 3'b101) && ((r_op == 2'b00) || (r_op == 2'b10));
  assign w_cmp           = (r_opcode == 3'b101) && (r_op == 2'b01);
  assign w_latched_legal = f_is_legal(r_opcode, r_op);
  assign w_start         = (r_state == S_WAIT) && bus.s;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT:      if (bus.s) w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_mov_imm)                  w_state_next = S_WRITE_IMM;
        else if (w_mov_reg || w_mvn)    w_state_next = S_GET_B;
        else if (w_add_and || w_cmp)    w_state_next = S_GET_A;
        else                            w_state_next = S_WAIT;
      end
      S_GET_A:     w_state_next = S_GET_B;
      S_GET_B:     w_state_next = S_ALU;
      S_ALU:       w_state_next = w_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_state_next = S_WAIT;
      S_WRITE_IMM: w_state_next = S_WAIT;
      default:     w_state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT;
      r_opcode <= 3'b000;
      r_op     <= 2'b00;
      r_w      <= 1'b1;
      r_nsel   <= 3'b000;
      r_vsel   <= 2'b00;
      r_loada  <= 1'b0;
      r_loadb  <= 1'b0;
      r_loadc  <= 1'b0;
      r_loads  <= 1'b0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_start) begin
        r_opcode <= bus.opcode;
        r_op     <= bus.op;
        // A legal instruction clears the flag as soon as it is accepted;
        // an illegal one leaves it alone until DECODE sets it.
        if (f_is_legal(bus.opcode, bus.op)) r_err <= 1'b0;
      end

      if ((r_state == S_DECODE) && !w_latched_legal) r_err <= 1'b1;

      // Load the Moore outputs of the state being entered.
      r_w     <= 1'b0;
      r_nsel  <= 3'b000;
      r_vsel  <= 2'b00;
      r_loada <= 1'b0;
      r_loadb <= 1'b0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_asel  <= 1'b0;
      r_bsel  <= 1'b0;
      r_write <= 1'b0;
      case (w_state_next)
        S_WAIT:      r_w <= 1'b1;
        S_GET_A: begin
          r_nsel  <= 3'b100;
          r_loada <= 1'b1;
        end
        S_GET_B: begin
          r_nsel  <= 3'b001;
          r_loadb <= 1'b1;
        end
        S_ALU: begin
          // CMP only updates status; moves pass B through with A forced to 0.
          if (w_cmp) begin
            r_loads <= 1'b1;
          end else begin
            r_loadc <= 1'b1;
            r_asel  <= w_mov_reg || w_mvn;
          end
        end
        S_WRITE_REG: begin
          r_nsel  <= 3'b010;
          r_vsel  <= 2'b00;
          r_write <= 1'b1;
        end
        S_WRITE_IMM: begin
          r_nsel  <= 3'b100;
          r_vsel  <= 2'b10;
          r_write <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.w     = r_w;
  assign bus.nsel  = r_nsel;
  assign bus.vsel  = r_vsel;
  assign bus.loada = r_loada;
  assign bus.loadb = r_loadb;
  assign bus.loadc = r_loadc;
  assign bus.loads = r_loads;
  assign bus.asel  = r_asel;
  assign bus.bsel  = r_bsel;
  assign bus.write = r_write;
  assign bus.err   = r_err;

endmodule

// File: doc/risc_fsm_controller.md
RISC_FSM_CONTROLLER -- requirements
Module: risc_fsm_controller

Interface
REQ-001 Clock and reset SHALL be: one clock, reset is asynchronous and active-high; ports named clk and reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 s  input  1  start pulse; request execution of the instruction currently held in the instruction register.
REQ-005 opcode  input  3  instruction[15:13] from the decoder.
REQ-006 op  input  2  instruction[12:11] from the decoder.
REQ-007 w  output  1  ready; 1 only in state WAIT.
REQ-008 nsel  output  3  register select, one-hot: 001 = Rm, 010 = Rd, 100 = Rn, 000 = none.
REQ-009 vsel  output  2  write-back source: 00 = datapath C, 10 = sximm8; 01 and 11 are never driven.
REQ-010 loada, loadb, loadc, loads  output  1 each  datapath register enables.
REQ-011 asel, bsel  output  1 each  ALU A-operand zero select; ALU B-operand sximm5 select (always 0 in this block).
REQ-012 write  output  1  register-file write enable.
REQ-013 err  output  1  sticky illegal-instruction flag.

Function
REQ-014 The state set SHALL be WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM.
REQ-015 All outputs SHALL be registered-state Moore outputs; any output not listed for a state SHALL be 0.
REQ-016 WAIT: w=1. On s=1 at a rising edge, latch opcode/op into internal registers and go to DECODE; otherwise remain in WAIT.
REQ-017 The latched opcode/op SHALL be the only source of every decode decision; input changes after the latch edge have no effect.
REQ-018 DECODE SHALL drive no enables and SHALL branch on the latched opcode/op as follows:
- 110/10 (MOV imm): go to WRITE_IMM.
- 110/00 (MOV reg): go to GET_B.
- 101/11 (MVN): go to GET_B.
- 101/00, 101/01, 101/10 (ADD/CMP/AND): go to GET_A.
- Any other combination: set err=1 and go to WAIT.
REQ-019 WRITE_IMM SHALL drive nsel=100, vsel=10, write=1, then go to WAIT.
REQ-020 GET_A SHALL drive nsel=100, loada=1, then go to GET_B.
REQ-021 GET_B SHALL drive nsel=001, loadb=1, then go to ALU.
REQ-022 ALU outputs by latched instruction:
- MOV reg: asel=1, loadc=1, then WRITE_REG.
- MVN: asel=1, loadc=1, then WRITE_REG.
- ADD/AND: asel=0, loadc=1, then WRITE_REG.
- CMP: loads=1, loadc=0, then WAIT (no write-back).
REQ-023 WRITE_REG SHALL drive nsel=010, vsel=00, write=1, then go to WAIT.
REQ-024 Latency, measured from the edge sampling s=1 to the edge returning to WAIT:
- MOV imm: 2 cycles.
- CMP: 4 cycles.
- MOV reg / MVN: 4 cycles.
- ADD / AND: 5 cycles.
- Illegal: 1 cycle.
REQ-025 s SHALL be ignored in every state other than WAIT; s held high in WAIT SHALL start a new instruction every time WAIT is re-entered.
REQ-026 err SHALL be cleared when a legal instruction is latched in WAIT and SHALL otherwise hold its value.
REQ-027 write SHALL never be 1 in two consecutive cycles, and nsel SHALL always be one-hot or zero.

Reset
REQ-028 Asserting reset SHALL force state WAIT immediately, independent of clk.
REQ-029 While reset is asserted, outputs SHALL be w=1, err=0, nsel=000, vsel=00, and every enable 0.
REQ-030 Reset mid-operation SHALL abort the instruction with no further write, loadc or loads pulse.
REQ-031 The first rising edge after reset deasserts SHALL behave as a normal WAIT edge.

Verification
REQ-032 Stimulus: reset, then s=1 with opcode=110, op=10. Required: DECODE, then WRITE_IMM with nsel=100, vsel=10, write=1 for exactly one cycle; w=1 on the 2nd edge.
REQ-033 Stimulus: ADD (101/00). Required sequence: loada with nsel=100; then loadb with nsel=001; then loadc with asel=0; then write with nsel=010, vsel=00; w returns 1 after 5 edges.
REQ-034 Stimulus: CMP (101/01). Required: loads=1 in ALU, no write pulse at any time; WAIT after 4 edges.
REQ-035 Stimulus: opcode=111. Required: err=1 and w=1 after 1 edge; a following MOV reg clears err when latched and completes in 4 edges with asel=1 in ALU.
REQ-036 Stimulus: MVN, with s toggled and opcode changed during GET_B, then reset asserted mid-clock in ALU. Required: decode unaffected by the changed inputs; all outputs go to reset values immediately; no write occurs.
